weight_bias_fetch: RTL and testbench

- Streams one row of layer weights, plus biases on the first row, from synchronous-read ROMs into parallel lane registers for the neuron datapath.
- Sits between master_controlpath and the CORDIC MAC array. It is triggered by the controller's weight_en/bias_en and uses its layer index n and input index i.
- Row for (n,i) = the ninl[n] weights connecting input i to every neuron of layer n.
- Presents weight_vec/bias_vec and a one-cycle vec_valid pulse before the controller enters compute.

---
 rtl/nn_pkg.sv | 14 +
 rtl/layer_base_calc.sv | 49 ++++
 rtl/weight_bias_fetch.sv | 140 ++++++++++++++
 tb/tb_weight_bias_fetch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, lane/layer limits and fetch FSM encoding for the neuron datapath
package nn_pkg;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 12;
    localparam int MAX_N      = 32;
    localparam int MAX_LAYERS = 5;
    localparam int NL_W       = 6;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_e;

    function automatic logic [ADDR_W-1:0] mul_a(input logic [NL_W-1:0] a, input logic [NL_W-1:0] b);
        return ADDR_W'(a) * ADDR_W'(b);
    endfunction
endpackage

// File: rtl/layer_base_calc.sv
// layer_base_calc: registered per-layer weight/bias ROM base addresses, recomputed on start
//   clk, rst   : clock, synchronous active-high reset (clears both tables)
//   start_i    : load new prefix sums from ninl_i
//   ninl_i     : neuron counts of layers 1..4 (layer 5 never contributes to a base)
//   wbase_o    : weight base of layer l at bits [l*ADDR_W +: ADDR_W]
//   bbase_o    : bias base, same packing
module layer_base_calc
    import nn_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [(MAX_LAYERS-1)*NL_W-1:0] ninl_i,
    output logic [MAX_LAYERS*ADDR_W-1:0] wbase_o,
    output logic [MAX_LAYERS*ADDR_W-1:0] bbase_o
);
    logic [MAX_LAYERS-2:0][NL_W-1:0]   ninl, fan;
    logic [MAX_LAYERS-1:0][ADDR_W-1:0] wbase_d, wbase_q, bbase_d, bbase_q;

    assign ninl = ninl_i;
    // fan-in of layer 0 is its own width (square input layer), later layers see the previous width
    assign fan  = {ninl[MAX_LAYERS-3:0], ninl[0]};

    always_comb begin
        wbase_d = wbase_q;
        bbase_d = bbase_q;
        if (start_i) begin
            wbase_d[0] = '0;
            bbase_d[0] = '0;
            for (int l = 1; l < MAX_LAYERS; l++) begin
                wbase_d[l] = wbase_d[l-1] + mul_a(fan[l-1], ninl[l-1]);
                bbase_d[l] = bbase_d[l-1] + ADDR_W'(ninl[l-1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbase_q <= '0;
            bbase_q <= '0;
        end else begin
            wbase_q <= wbase_d;
            bbase_q <= bbase_d;
        end
    end

    assign wbase_o = wbase_q;
    assign bbase_o = bbase_q;
endmodule

// File: rtl/weight_bias_fetch.sv
// weight_bias_fetch: streams one weight row (and first-row biases) from ROMs into parallel lane registers
//   clk, rst                : clock, synchronous active-high reset
//   start_i                 : inference start, recomputes layer bases and clears fetch_err_o
//   nl1_i..nl5_i            : neurons per layer
//   n_i, i_i                : layer index and input index from the controller
//   weight_en_i, bias_en_i  : fetch window and bias qualifier
//   w_rd_*, b_rd_*          : synchronous-read ROM ports (data one cycle after enable)
//   weight_vec_o/bias_vec_o : lane k at [k*DATA_W +: DATA_W]
//   vec_valid_o             : one-cycle pulse when the row is complete
//   fetch_err_o             : sticky abort/reject flag
module weight_bias_fetch
    import nn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [NL_W-1:0]         nl1_i,
    input  logic [NL_W-1:0]         nl2_i,
    input  logic [NL_W-1:0]         nl3_i,
    input  logic [NL_W-1:0]         nl4_i,
    input  logic [NL_W-1:0]         nl5_i,
    input  logic [NL_W-1:0]         n_i,
    input  logic [NL_W-1:0]         i_i,
    input  logic                    weight_en_i,
    input  logic                    bias_en_i,
    output logic                    w_rd_en_o,
    output logic [ADDR_W-1:0]       w_rd_addr_o,
    input  logic [DATA_W-1:0]       w_rd_data_i,
    output logic                    b_rd_en_o,
    output logic [ADDR_W-1:0]       b_rd_addr_o,
    input  logic [DATA_W-1:0]       b_rd_data_i,
    output logic [MAX_N*DATA_W-1:0] weight_vec_o,
    output logic [MAX_N*DATA_W-1:0] bias_vec_o,
    output logic                    vec_valid_o,
    output logic                    fetch_err_o
);
    state_e                    state_q, state_d;
    logic [MAX_LAYERS*ADDR_W-1:0] wbase_w, bbase_w;
    // tables padded to 8 entries so a 3-bit index never leaves the array; pad layers read as empty
    logic [7:0][ADDR_W-1:0]    wb_tab, bb_tab;
    logic [7:0][NL_W-1:0]      nl_tab;
    logic [NL_W-1:0]           n_sel, n_lanes_q, k_q;
    logic [ADDR_W-1:0]         row_q, brow_q;
    logic [4:0]                cap_k_q;
    logic [MAX_N*DATA_W-1:0]   wvec_q, bvec_q;
    logic we_q, start_q, do_bias_q, cap_q, cap_b_q, valid_q, err_q;
    logic n_ok, bad, trig, abort, last, fetching, new_bias;

    layer_base_calc u_base (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .ninl_i  ({nl4_i, nl3_i, nl2_i, nl1_i}),
        .wbase_o (wbase_w),
        .bbase_o (bbase_w)
    );

    assign wb_tab   = (8*ADDR_W)'(wbase_w);
    assign bb_tab   = (8*ADDR_W)'(bbase_w);
    assign nl_tab   = (8*NL_W)'({nl5_i, nl4_i, nl3_i, nl2_i, nl1_i});
    assign n_ok     = n_i < NL_W'(MAX_LAYERS);
    assign n_sel    = n_ok ? nl_tab[n_i[2:0]] : '0;
    assign bad      = ~n_ok | (n_sel == '0) | (n_sel > NL_W'(MAX_N));
    // the cycle after start also triggers so a start coincident with a weight_en rise is not lost
    assign trig     = weight_en_i & (~we_q | start_q) & ~start_i & (state_q == IDLE);
    assign abort    = ~weight_en_i & ((state_q == FETCH) | (state_q == DRAIN));
    assign last     = k_q == n_lanes_q - NL_W'(1);
    assign fetching = state_q == FETCH;
    assign new_bias = bias_en_i & (i_i == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (trig & ~bad) ? FETCH : IDLE;
            FETCH:   state_d = abort ? IDLE : (last ? DRAIN : FETCH);
            DRAIN:   state_d = abort ? IDLE : HOLD;
            HOLD:    state_d = weight_en_i ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
        if (start_i) state_d = IDLE;
    end

    always_comb begin
        w_rd_en_o   = fetching;
        w_rd_addr_o = fetching ? row_q + ADDR_W'(k_q) : '0;
        b_rd_en_o   = fetching & do_bias_q;
        b_rd_addr_o = (fetching & do_bias_q) ? brow_q + ADDR_W'(k_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            start_q   <= 1'b0;
            n_lanes_q <= '0;
            k_q       <= '0;
            row_q     <= '0;
            brow_q    <= '0;
            do_bias_q <= 1'b0;
            cap_q     <= 1'b0;
            cap_b_q   <= 1'b0;
            cap_k_q   <= '0;
            wvec_q    <= '0;
            bvec_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            we_q    <= weight_en_i;
            start_q <= start_i;
            valid_q <= (state_q == DRAIN) & ~abort & ~start_i;
            // ROM data lags the strobe by one cycle, so the lane index travels with it
            cap_q   <= w_rd_en_o;
            cap_b_q <= b_rd_en_o;
            cap_k_q <= k_q[4:0];
            if (cap_q)   wvec_q[cap_k_q*DATA_W +: DATA_W] <= w_rd_data_i;
            if (cap_b_q) bvec_q[cap_k_q*DATA_W +: DATA_W] <= b_rd_data_i;
            if (fetching) k_q <= k_q + NL_W'(1);
            if (start_i) err_q <= 1'b0;
            else if ((trig & bad) | abort) err_q <= 1'b1;
            if (trig & ~bad) begin
                n_lanes_q <= n_sel;
                row_q     <= wb_tab[n_i[2:0]] + mul_a(i_i, n_sel);
                brow_q    <= bb_tab[n_i[2:0]];
                do_bias_q <= new_bias;
                k_q       <= '0;
                wvec_q    <= '0;
                if (new_bias) bvec_q <= '0;
            end
        end
    end

    assign weight_vec_o = wvec_q;
    assign bias_vec_o   = bvec_q;
    assign vec_valid_o  = valid_q;
    assign fetch_err_o  = err_q;
endmodule

// File: tb/tb_weight_bias_fetch.sv
// tb_weight_bias_fetch: scoreboard bench for weight_bias_fetch with behavioural ROMs
module tb_weight_bias_fetch;
    import nn_pkg::*;
    localparam int VW = MAX_N*DATA_W;

    logic clk = 0, rst = 1, start = 0, weight_en = 0, bias_en = 0;
    logic [NL_W-1:0] nl1 = 0, nl2 = 0, nl3 = 0, nl4 = 0, nl5 = 0, n = 0, i = 0;
    logic w_rd_en, b_rd_en, vec_valid, fetch_err;
    logic [ADDR_W-1:0] w_rd_addr, b_rd_addr;
    logic [DATA_W-1:0] w_rd_data = 0, b_rd_data = 0;
    logic [VW-1:0] weight_vec, bias_vec, exp_bias = '0;
    int n_checks = 0, n_fail = 0;
    int cfg[5], wb[5], bb[5];
    int wq[$], bq[$];

    weight_bias_fetch dut (
        .clk(clk), .rst(rst), .start_i(start),
        .nl1_i(nl1), .nl2_i(nl2), .nl3_i(nl3), .nl4_i(nl4), .nl5_i(nl5),
        .n_i(n), .i_i(i), .weight_en_i(weight_en), .bias_en_i(bias_en),
        .w_rd_en_o(w_rd_en), .w_rd_addr_o(w_rd_addr), .w_rd_data_i(w_rd_data),
        .b_rd_en_o(b_rd_en), .b_rd_addr_o(b_rd_addr), .b_rd_data_i(b_rd_data),
        .weight_vec_o(weight_vec), .bias_vec_o(bias_vec),
        .vec_valid_o(vec_valid), .fetch_err_o(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] wv(input logic [11:0] a);
        return 16'(a) * 16'd37 + 16'h1234;
    endfunction

    function automatic logic [15:0] bv(input logic [11:0] a);
        return (16'(a) * 16'd91) ^ 16'hBEEF;
    endfunction

    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= wv(w_rd_addr);
        if (b_rd_en) b_rd_data <= bv(b_rd_addr);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_cfg(input int a, input int b, input int c, input int d, input int e);
        cfg = '{a, b, c, d, e};
        nl1 = 6'(a); nl2 = 6'(b); nl3 = 6'(c); nl4 = 6'(d); nl5 = 6'(e);
    endtask

    task automatic model_bases;
        wb[0] = 0;
        bb[0] = 0;
        for (int l = 1; l < 5; l++) begin
            wb[l] = (wb[l-1] + (l == 1 ? cfg[0] : cfg[l-2]) * cfg[l-1]) % 4096;
            bb[l] = (bb[l-1] + cfg[l-1]) % 4096;
        end
    endtask

    task automatic pulse_start;
        start = 1;
        tick;
        start = 0;
        model_bases();
    endtask

    task automatic test_reset;
        rst = 1;
        tick;
        tick;
        n_checks++;
        if ({w_rd_en, b_rd_en, vec_valid, fetch_err, w_rd_addr, b_rd_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got en=%b/%b valid=%b err=%b addr=%0d/%0d, want all 0", w_rd_en, b_rd_en, vec_valid, fetch_err, w_rd_addr, b_rd_addr);
        end
        n_checks++;
        if ({weight_vec, bias_vec} !== '0) begin
            n_fail++;
            $display("FAIL reset_vec: vectors not zero");
        end
        rst = 0;
        tick;
    endtask

    task automatic fetch_row(input int nn_idx, input int ii, input bit bias, input bit with_start, input string tag);
        int nn, rb;
        bit db;
        logic [VW-1:0] ew, eb;
        if (with_start) model_bases();
        nn = cfg[nn_idx];
        rb = (wb[nn_idx] + ii * nn) % 4096;
        db = bias && ii == 0;
        ew = '0;
        eb = db ? '0 : exp_bias;
        for (int k = 0; k < nn; k++) begin
            wq.push_back((rb + k) % 4096);
            ew[k*DATA_W +: DATA_W] = wv(12'(rb + k));
            if (db) begin
                bq.push_back((bb[nn_idx] + k) % 4096);
                eb[k*DATA_W +: DATA_W] = bv(12'(bb[nn_idx] + k));
            end
        end
        n = 6'(nn_idx); i = 6'(ii); bias_en = bias; weight_en = 1; start = with_start;
        if (with_start) begin
            tick;
            start = 0;
            n_checks++;
            if (w_rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL %s start_cycle_rd: got %b want 0", tag, w_rd_en);
            end
        end
        for (int m = 1; m <= nn + 4; m++) begin
            tick;
            n_checks++;
            if (w_rd_en !== (m <= nn)) begin
                n_fail++;
                $display("FAIL %s w_rd_en@T+%0d: got %b want %b", tag, m, w_rd_en, m <= nn);
            end
            if (w_rd_en && wq.size() > 0) begin
                int ea = wq.pop_front();
                n_checks++;
                if (w_rd_addr !== 12'(ea)) begin
                    n_fail++;
                    $display("FAIL %s w_rd_addr@T+%0d: got %0d want %0d", tag, m, w_rd_addr, ea);
                end
            end
            n_checks++;
            if (b_rd_en !== (db && m <= nn)) begin
                n_fail++;
                $display("FAIL %s b_rd_en@T+%0d: got %b want %b", tag, m, b_rd_en, db && m <= nn);
            end
            if (b_rd_en && bq.size() > 0) begin
                int ea = bq.pop_front();
                n_checks++;
                if (b_rd_addr !== 12'(ea)) begin
                    n_fail++;
                    $display("FAIL %s b_rd_addr@T+%0d: got %0d want %0d", tag, m, b_rd_addr, ea);
                end
            end
            n_checks++;
            if (vec_valid !== (m == nn + 2)) begin
                n_fail++;
                $display("FAIL %s vec_valid@T+%0d: got %b want %b", tag, m, vec_valid, m == nn + 2);
            end
        end
        n_checks++;
        if (wq.size() != 0 || bq.size() != 0) begin
            n_fail++;
            $display("FAIL %s reads_missing: got %0d/%0d pending want 0/0", tag, wq.size(), bq.size());
            wq.delete();
            bq.delete();
        end
        n_checks++;
        if (weight_vec !== ew) begin
            n_fail++;
            $display("FAIL %s weight_vec: got %h want %h", tag, weight_vec, ew);
        end
        n_checks++;
        if (bias_vec !== eb) begin
            n_fail++;
            $display("FAIL %s bias_vec: got %h want %h", tag, bias_vec, eb);
        end
        n_checks++;
        if (fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s fetch_err: got %b want 0", tag, fetch_err);
        end
        exp_bias = eb;
        weight_en = 0;
        tick;
        tick;
    endtask

    task automatic test_first_row;
        apply_cfg(4, 3, 2, 1, 1);
        pulse_start();
        fetch_row(0, 0, 1, 0, "row0");
    endtask

    task automatic test_no_bias_row;
        fetch_row(1, 2, 1, 0, "row_n1_i2");
    endtask

    task automatic test_abort;
        bit saw = 0;
        pulse_start();
        n = 0; i = 0; bias_en = 0; weight_en = 1;
        tick;
        tick;
        weight_en = 0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (vec_valid) saw = 1;
        end
        n_checks++;
        if (saw) begin
            n_fail++;
            $display("FAIL abort_valid: got vec_valid pulse want none");
        end
        n_checks++;
        if (fetch_err !== 1'b1 || w_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_err: got err=%b rd=%b want err=1 rd=0", fetch_err, w_rd_en);
        end
        pulse_start();
        n_checks++;
        if (fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_clear: got err=%b want 0", fetch_err);
        end
    endtask

    task automatic test_reject;
        int reads = 0;
        apply_cfg(40, 3, 2, 1, 1);
        pulse_start();
        n = 0; i = 0; bias_en = 1; weight_en = 1;
        for (int c = 0; c < 6; c++) begin
            tick;
            reads += int'(w_rd_en) + int'(b_rd_en);
        end
        n_checks++;
        if (reads != 0 || fetch_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reject_big: got reads=%0d err=%b want 0/1", reads, fetch_err);
        end
        weight_en = 0;
        apply_cfg(4, 3, 2, 1, 1);
        pulse_start();
        n = 5; weight_en = 1;
        for (int c = 0; c < 6; c++) begin
            tick;
            reads += int'(w_rd_en) + int'(b_rd_en);
        end
        n_checks++;
        if (reads != 0 || fetch_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reject_layer: got reads=%0d err=%b want 0/1", reads, fetch_err);
        end
        weight_en = 0;
        tick;
    endtask

    task automatic test_reset_mid_fetch;
        apply_cfg(4, 3, 2, 1, 1);
        pulse_start();
        n = 0; i = 0; bias_en = 1; weight_en = 1;
        tick;
        tick;
        rst = 1;
        weight_en = 0;
        tick;
        n_checks++;
        if ({w_rd_en, b_rd_en, vec_valid, fetch_err, w_rd_addr, b_rd_addr} !== '0 || {weight_vec, bias_vec} !== '0) begin
            n_fail++;
            $display("FAIL midreset: got en=%b/%b valid=%b err=%b addr=%0d/%0d, want all 0", w_rd_en, b_rd_en, vec_valid, fetch_err, w_rd_addr, b_rd_addr);
        end
        rst = 0;
        wb = '{0, 0, 0, 0, 0};
        bb = '{0, 0, 0, 0, 0};
        exp_bias = '0;
        tick;
        fetch_row(1, 1, 1, 0, "after_reset");
    endtask

    task automatic test_start_and_trigger;
        apply_cfg(5, 6, 3, 2, 2);
        fetch_row(2, 0, 1, 1, "start_trig");
    endtask

    initial begin
        test_reset();
        test_first_row();
        test_no_bias_row();
        test_abort();
        test_reject();
        test_reset_mid_fetch();
        test_start_and_trigger();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
